fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the instruction memory ROM. It holds the program counter and drives the ROM address combinationally. It captures the returned word into an IF/ID pipeline register for the decode stage. It supports stall, flush and PC redirect for branches and jumps. The ROM is asynchronous-read, so a fetched word is registered in the same cycle its address is presented.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 1, PC increment per fetch (1 = word-addressed ROM; 4 = byte-addressed)
NOP_WORD, 32'h0000_0000, instruction inserted into IF/ID on flush or redirect (MIPS sll $0,$0,0)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC and IF/ID contents (hazard unit)
flush  in  1  invalidate IF/ID this cycle
redirect  in  1  load redirect_pc into PC (taken branch/jump)
redirect_pc  in  32  redirect target
imem_addr  out  32  address to instruction memory; equals PC
imem_word  in  32  instruction word returned by instruction memory
ifid_instr  out  32  registered instruction
ifid_pc  out  32  PC of ifid_instr
ifid_pc_next  out  32  ifid_pc + PC_STEP (link / branch base)
ifid_valid  out  1  ifid_instr is a real fetched instruction

Behaviour:
- Reset (async, active-high): pc = RESET_PC; ifid_instr = NOP_WORD; ifid_pc = 0; ifid_pc_next = 0; ifid_valid = 0.
- imem_addr = pc, purely combinational from the pc register with no added logic.
- PC update at each rising edge, by priority:
  1. redirect=1: pc <= redirect_pc. This overrides stall.
  2. stall=1: pc holds.
  3. Otherwise: pc <= pc + PC_STEP, modulo 2^32. 32'hFFFF_FFFF+1 wraps to 0 without error.
- IF/ID update at each rising edge, by priority:
  1. redirect=1 or flush=1: ifid_instr <= NOP_WORD; ifid_valid <= 0; ifid_pc and ifid_pc_next <= 0.
  2. stall=1: all IF/ID fields hold.
  3. Otherwise: ifid_instr <= imem_word; ifid_pc <= pc; ifid_pc_next <= pc + PC_STEP; ifid_valid <= 1.
- Latency: the word at address A appears on ifid_instr one cycle after imem_addr = A.
- flush without redirect: PC still advances (unless stall=1); only IF/ID is squashed.
- flush=1 and stall=1 together: flush wins for IF/ID; PC holds.
- redirect=1 and stall=1 together: PC loads the target and IF/ID is squashed. A stall must never swallow a taken branch.
- Reset asserted mid-operation: outputs go to reset values immediately. The first fetch after deassertion is from RESET_PC.
- redirect_pc alignment is not checked. Low bits pass through unchanged.

Optional Feature:
FETCH_PERF_CNT_EN
- When defined: adds outputs perf_fetched (32) and perf_stalled (32).
  - perf_fetched increments on every cycle that loads IF/ID with ifid_valid <= 1.
  - perf_stalled increments on every cycle with stall=1 and redirect=0.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined: these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - XLEN = 32
  - NOP_WORD default
  - RESET_PC default
  - the PC_STEP default
- One natural sub-module: pc_register. It holds the PC flop, the redirect/stall/increment mux and the async reset. fetch_stage instantiates it plus the IF/ID register logic.

Test Plan:
- Reset then run 4 cycles, stall=0, ROM preloaded with word[i]=32'h1000_0000+i -> imem_addr 0,1,2,3. ifid_instr is 0x10000000 then 0x10000001, 0x10000002 one cycle behind. ifid_valid goes 0→1 after the first edge.
- stall=1 for 3 cycles at pc=5 -> imem_addr stays 5. ifid_instr/ifid_pc stay at pc=4 values. Resumes 5,6 after release.
- redirect=1, redirect_pc=0x40, at pc=7 -> next imem_addr=0x40. IF/ID=NOP_WORD with ifid_valid=0 for one cycle, then the word from 0x40 with ifid_pc=0x40.
- redirect=1 and stall=1 in the same cycle, target 0x20 -> pc=0x20, IF/ID squashed. Also flush=1 alone at pc=9 -> pc=10, ifid_valid=0.
- Force pc to 32'hFFFF_FFFF via redirect, then one free cycle -> imem_addr=0. ifid_pc_next=0 for the 0xFFFFFFFF entry.
- Assert reset asynchronously mid-cycle at pc=0x33 -> outputs reset immediately without a clock edge. After release, fetch starts at RESET_PC. With FETCH_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// The optional FETCH_PERF_CNT_EN macro is consumed by fetch_stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP_DEFAULT  = 32'd1;
    localparam logic [XLEN-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
        logic            valid;
    } ifid_t;

    // Wraps modulo 2^XLEN by construction.
    function automatic logic [XLEN-1:0] pc_advance(input logic [XLEN-1:0] pc,
                                                   input logic [XLEN-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter flop with redirect > stall > increment next-state selection.
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_inc_o
);

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    assign pc_inc_o = pc_advance(pc_q, PC_STEP);
    assign pc_o     = pc_q;

    // A taken branch must never be swallowed by a stall.
    always_comb begin
        pc_d = pc_inc_o;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, asynchronous-ROM address and IF/ID pipeline register.
// Define FETCH_PERF_CNT_EN to add the fetched/stalled performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT,
    parameter logic [XLEN-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_word_i,
    output logic [XLEN-1:0] ifid_instr_o,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_pc_next_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [XLEN-1:0] perf_fetched_o,
    output logic [XLEN-1:0] perf_stalled_o,
`endif
    output logic            ifid_valid_o
);

    localparam ifid_t IFID_SQUASH = '{instr: NOP_WORD, pc: '0, pc_next: '0, valid: 1'b0};

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inc;
    logic            squash;
    logic            load;
    ifid_t           ifid_d;
    ifid_t           ifid_q;

    pc_register #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_register (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc),
        .pc_inc_o      (pc_inc)
    );

    assign imem_addr_o = pc;
    assign squash      = redirect_i | flush_i;
    assign load        = ~squash & ~stall_i;

    always_comb begin
        ifid_d = ifid_q;
        if (squash) begin
            ifid_d = IFID_SQUASH;
        end else if (load) begin
            ifid_d = '{instr: imem_word_i, pc: pc, pc_next: pc_inc, valid: 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ifid_q <= IFID_SQUASH;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_instr_o   = ifid_q.instr;
    assign ifid_pc_o      = ifid_q.pc;
    assign ifid_pc_next_o = ifid_q.pc_next;
    assign ifid_valid_o   = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] perf_fetched_q;
    logic [XLEN-1:0] perf_stalled_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            perf_fetched_q <= '0;
            perf_stalled_q <= '0;
        end else begin
            if (load) begin
                perf_fetched_q <= perf_fetched_q + 1'b1;
            end
            if (stall_i && !redirect_i) begin
                perf_stalled_q <= perf_stalled_q + 1'b1;
            end
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_stalled_o = perf_stalled_q;
`endif

endmodule
